// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
// The master side (E stage) drives the operation and operands. The slave side
// (md_unit) returns Busy, the architectural HI/LO registers and the read mux.
interface md_unit_if;
  logic        E_Start;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_Out;

  modport master (
    output E_Start,
    output E_MDOp,
    output E_A,
    output E_B,
    input  Busy,
    input  HI,
    input  LO,
    input  MD_Out
  );

  modport slave (
    input  E_Start,
    input  E_MDOp,
    input  E_A,
    input  E_B,
    output Busy,
    output HI,
    output LO,
    output MD_Out
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// The result is computed when the operation is accepted and parked in a pending
// register. Busy is then held for a fixed number of cycles, so that the stall
// logic sees the same latency a real iterative unit would have. HI/LO only
// change on the last busy edge, and they change at the same time as Busy drops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  md_unit_if.slave    md
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [63:0] pend_r;
  logic        start_op_s;
  logic        is_mult_s;
  logic [31:0] md_out_s;

  // Full {HI,LO} result of one operation. The divide corner cases are handled
  // explicitly so that the outcome never depends on how the tool treats x/0 or
  // on signed overflow.
  function automatic logic [63:0] md_compute(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0]        a_ext;
    logic [63:0]        b_ext;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0]        res;
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    sa    = a;
    sb    = b;
    res   = 64'd0;
    case (op)
      OP_MULT:  res = a_ext * b_ext;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {$unsigned(sa % sb), $unsigned(sa / sb)};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {a % b, a / b};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Decode whether the E-stage op is a start-able arithmetic op, and which latency it uses.
  always_comb begin
    start_op_s = 1'b0;
    is_mult_s  = 1'b0;
    case (md.E_MDOp)
      OP_MULT, OP_MULTU: begin
        start_op_s = 1'b1;
        is_mult_s  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        start_op_s = 1'b1;
        is_mult_s  = 1'b0;
      end
      default: begin
        start_op_s = 1'b0;
        is_mult_s  = 1'b0;
      end
    endcase
  end

  // mfhi/mflo read mux. Only the committed HI/LO are visible; an in-flight result is never forwarded.
  always_comb begin
    md_out_s = 32'd0;
    case (md.E_MDOp)
      OP_MFHI: md_out_s = hi_r;
      OP_MFLO: md_out_s = lo_r;
      default: md_out_s = 32'd0;
    endcase
  end

  // Sequencer: accepts ops in IDLE, counts down in BUSY, then commits pending to HI/LO on the last edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      pend_r  <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (md.E_Start && start_op_s) begin
            pend_r  <= md_compute(md.E_MDOp, md.E_A, md.E_B);
            cnt_r   <= is_mult_s ? MULT_CNT : DIV_CNT;
            state_r <= BUSY;
            busy_r  <= 1'b1;
          end else if (md.E_MDOp == OP_MTHI) begin
            hi_r <= md.E_A;
          end else if (md.E_MDOp == OP_MTLO) begin
            lo_r <= md.E_A;
          end
        end
        BUSY: begin
          // Starts and mthi/mtlo are ignored here. The stall unit should have blocked them anyway.
          if (cnt_r <= 4'd1) begin
            hi_r    <= pend_r[63:32];
            lo_r    <= pend_r[31:0];
            cnt_r   <= 4'd0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign md.Busy   = busy_r;
  assign md.HI     = hi_r;
  assign md.LO     = lo_r;
  assign md.MD_Out = md_out_s;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit. Each operation is given hand-computed HI/LO values.
// A small HI/LO shadow checks that HI/LO hold their values while Busy is high.
module tb_md_unit;

  logic clk;
  logic reset_n;
  int   checks_cnt;
  int   errors_cnt;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_unit_if mif ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op, scramble the operands after acceptance, and walk the busy window.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit inject);
    mif.E_Start = 1'b1;
    mif.E_MDOp  = op;
    mif.E_A     = a;
    mif.E_B     = b;
    tick;
    mif.E_Start = 1'b0;
    mif.E_MDOp  = 4'd0;
    mif.E_A     = ~a;
    mif.E_B     = b + 32'd3;
    for (int i = 0; i < n; i++) begin
      check("busy_high", {31'd0, mif.Busy}, 32'd1);
      check("hi_hold", mif.HI, hi_m);
      check("lo_hold", mif.LO, lo_m);
      if (inject && i == 2) begin
        mif.E_Start = 1'b1;
        mif.E_MDOp  = 4'd3;
        mif.E_A     = 32'd9;
        mif.E_B     = 32'd3;
      end else if (inject && i == 3) begin
        mif.E_Start = 1'b0;
        mif.E_MDOp  = 4'd7;
        mif.E_A     = 32'h0000_1234;
      end else if (inject && i == 4) begin
        mif.E_MDOp = 4'd5;
        #1;
        check("mfhi_in_busy", mif.MD_Out, hi_m);
        mif.E_MDOp = 4'd0;
      end
      tick;
    end
    check("busy_done", {31'd0, mif.Busy}, 32'd0);
    check("hi_result", mif.HI, exp_hi);
    check("lo_result", mif.LO, exp_lo);
    hi_m = exp_hi;
    lo_m = exp_lo;
  endtask

  initial begin
    clk         = 1'b0;
    reset_n     = 1'b0;
    checks_cnt  = 0;
    errors_cnt  = 0;
    hi_m        = 32'd0;
    lo_m        = 32'd0;
    mif.E_Start = 1'b0;
    mif.E_MDOp  = 4'd0;
    mif.E_A     = 32'd0;
    mif.E_B     = 32'd0;

    #1;
    check("rst_busy", {31'd0, mif.Busy}, 32'd0);
    check("rst_hi", mif.HI, 32'd0);
    check("rst_lo", mif.LO, 32'd0);
    #13 reset_n = 1'b1;
    tick;

    // A start with a non-arithmetic op code is ignored.
    mif.E_Start = 1'b1;
    mif.E_MDOp  = 4'd9;
    mif.E_A     = 32'h5555_0000;
    tick;
    check("bad_start_busy", {31'd0, mif.Busy}, 32'd0);
    check("bad_start_hi", mif.HI, 32'd0);
    mif.E_Start = 1'b0;
    mif.E_MDOp  = 4'd0;

    // mthi, mtlo, mfhi and mflo while the unit is idle.
    mif.E_MDOp = 4'd7;
    mif.E_A    = 32'hAAAA_5555;
    tick;
    check("mthi_busy", {31'd0, mif.Busy}, 32'd0);
    check("mthi_hi", mif.HI, 32'hAAAA_5555);
    mif.E_MDOp = 4'd8;
    mif.E_A    = 32'h0F0F_0F0F;
    tick;
    check("mtlo_lo", mif.LO, 32'h0F0F_0F0F);
    check("mtlo_hi_kept", mif.HI, 32'hAAAA_5555);
    mif.E_MDOp = 4'd5;
    #1;
    check("mfhi", mif.MD_Out, 32'hAAAA_5555);
    mif.E_MDOp = 4'd6;
    #1;
    check("mflo", mif.MD_Out, 32'h0F0F_0F0F);
    mif.E_MDOp = 4'd0;
    #1;
    check("md_out_none", mif.MD_Out, 32'd0);
    check("mt_busy_low", {31'd0, mif.Busy}, 32'd0);
    hi_m = 32'hAAAA_5555;
    lo_m = 32'h0F0F_0F0F;
    tick;

    // Arithmetic, issued back-to-back with no idle bubble.
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    run_op(4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);
    run_op(4'd4, 32'h0000_DEAD, 32'd0, 10, 32'h0000_DEAD, 32'hFFFF_FFFF, 1'b0);
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0, 1'b0);
    // Restart, mthi and mfhi during BUSY: 100 / 7 = 14 remainder 2.
    run_op(4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, 1'b0);

    // Asynchronous reset in the middle of an operation with HI nonzero.
    mif.E_MDOp = 4'd7;
    mif.E_A    = 32'hCAFE_0000;
    tick;
    mif.E_MDOp = 4'd0;
    check("pre_rst_hi", mif.HI, 32'hCAFE_0000);
    mif.E_Start = 1'b1;
    mif.E_MDOp  = 4'd1;
    mif.E_A     = 32'd3;
    mif.E_B     = 32'd4;
    tick;
    mif.E_Start = 1'b0;
    mif.E_MDOp  = 4'd0;
    check("pre_rst_busy", {31'd0, mif.Busy}, 32'd1);
    tick;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, mif.Busy}, 32'd0);
    check("async_rst_hi", mif.HI, 32'd0);
    check("async_rst_lo", mif.LO, 32'd0);
    tick;
    #2 reset_n = 1'b1;
    tick;
    tick;
    tick;
    tick;
    check("post_rst_busy", {31'd0, mif.Busy}, 32'd0);
    check("post_rst_hi", mif.HI, 32'd0);
    check("post_rst_lo", mif.LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    run_op(4'd4, 32'd9, 32'd4, 10, 32'd1, 32'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
